// File: rtl/digital_clock_pkg.sv
// Shared field widths, mode constants, digit limits and the BCD time validity check
// used by the hh:mm:ss clock.
package digital_clock_pkg;

  localparam int unsigned HR_W  = 6;
  localparam int unsigned MIN_W = 7;
  localparam int unsigned SEC_W = 7;

  localparam int unsigned HOUR_MODE_12 = 12;
  localparam int unsigned HOUR_MODE_24 = 24;

  localparam int unsigned ONES_MAX    = 9;
  localparam int unsigned TENS_MAX_MS = 5;
  localparam int unsigned HR_MAX_24   = 23;
  localparam int unsigned HR_MAX_12   = 12;

  // Seconds are passed as 0 when only hr:min matter (alarm capture).
  function automatic logic bcd_time_valid(input logic [HR_W-1:0]  hr,
                                          input logic [MIN_W-1:0] mn,
                                          input logic [SEC_W-1:0] sec,
                                          input int unsigned      mode);
    int unsigned h;
    logic        digits_ok;
    logic        hr_ok;
    h = 32'(hr[5:4]) * 10 + 32'(hr[3:0]);
    digits_ok = (hr[3:0] <= 4'(ONES_MAX)) && (mn[3:0] <= 4'(ONES_MAX)) &&
                (sec[3:0] <= 4'(ONES_MAX)) && (mn[6:4] <= 3'(TENS_MAX_MS)) &&
                (sec[6:4] <= 3'(TENS_MAX_MS));
    if (mode == HOUR_MODE_12) hr_ok = (h >= 1) && (h <= HR_MAX_12);
    else                      hr_ok = (h <= HR_MAX_24);
    return digits_ok && hr_ok;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (tens/ones) with increment, parallel load and carry out.
// The combinational next value is exported so callers can look one edge ahead.
module bcd_mod_counter #(
  parameter int unsigned MAX_TENS = 5,
  parameter int unsigned MAX_ONES = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [6:0] load_val,
  output logic [6:0] value,
  output logic [6:0] nxt,
  output logic       carry
);

  logic [6:0] value_q;
  logic       at_max;

  assign at_max = (value_q[6:4] == 3'(MAX_TENS)) && (value_q[3:0] == 4'(MAX_ONES));
  assign carry  = inc && at_max;
  assign value  = value_q;

  always_comb begin
    nxt = value_q;
    if (inc) begin
      if (at_max)                          nxt = 7'h00;
      else if (value_q[3:0] == 4'(MAX_ONES)) nxt = {value_q[6:4] + 3'd1, 4'd0};
      else                                 nxt = {value_q[6:4], value_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     value_q <= 7'h00;
    else if (load) value_q <= load_val;
    else           value_q <= nxt;
  end

endmodule

// File: rtl/digital_clock_hms.sv
// BCD hh:mm:ss time-of-day clock with 1 s prescaler, 12/24-hour mode, validated load and
// a single hr:min alarm with sticky hit flag.
module digital_clock_hms
  import digital_clock_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned HOUR_MODE = 24,
  parameter int unsigned ALARM_EN  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [5:0] load_hr,
  input  logic [6:0] load_min,
  input  logic [6:0] load_sec,
  input  logic       load_pm,
  input  logic       alarm_set,
  input  logic       alarm_clr,
  output logic [5:0] time_hr,
  output logic [6:0] time_min,
  output logic [6:0] time_sec,
  output logic       time_pm,
  output logic       sec_tick,
  output logic       load_err,
  output logic       alarm_hit
);

  localparam bit              Mode12  = (HOUR_MODE == HOUR_MODE_12);
  localparam int unsigned     CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(TICK_DIV - 1);
  localparam logic [5:0]      HrReset = Mode12 ? 6'h12 : 6'h00;

  logic [CntW-1:0] presc_q;
  logic [5:0]      hr_q, hr_nxt, hr_inc;
  logic            pm_q, pm_nxt;
  logic            sec_tick_q, load_err_q;
  logic [6:0]      sec_q, sec_nxt, min_q, min_nxt;
  logic            sec_carry, min_carry;
  logic            tick, adv;
  logic            load_valid, load_ok, load_bad;
  logic            alarm_valid, alarm_ok, alarm_bad;

  assign tick        = enable && (presc_q == TermCnt);
  assign load_valid  = bcd_time_valid(load_hr, load_min, load_sec, HOUR_MODE);
  assign alarm_valid = bcd_time_valid(load_hr, load_min, 7'h00, HOUR_MODE);
  assign load_ok     = load && load_valid;
  assign load_bad    = load && !load_valid;
  // A valid load swallows a coincident tick; a rejected one leaves the tick alone.
  assign adv         = tick && !load_ok;

  bcd_mod_counter #(.MAX_TENS(TENS_MAX_MS), .MAX_ONES(ONES_MAX)) u_sec (
    .clock    (clock),
    .reset    (reset),
    .inc      (adv),
    .load     (load_ok),
    .load_val (load_sec),
    .value    (sec_q),
    .nxt      (sec_nxt),
    .carry    (sec_carry)
  );

  bcd_mod_counter #(.MAX_TENS(TENS_MAX_MS), .MAX_ONES(ONES_MAX)) u_min (
    .clock    (clock),
    .reset    (reset),
    .inc      (sec_carry),
    .load     (load_ok),
    .load_val (load_min),
    .value    (min_q),
    .nxt      (min_nxt),
    .carry    (min_carry)
  );

  assign hr_inc = (hr_q[3:0] == 4'(ONES_MAX)) ? {hr_q[5:4] + 2'd1, 4'd0}
                                              : {hr_q[5:4], hr_q[3:0] + 4'd1};

  always_comb begin
    hr_nxt = hr_q;
    pm_nxt = pm_q;
    if (min_carry) begin
      if (Mode12) begin
        if (hr_q == 6'h12) begin
          hr_nxt = 6'h01;
        end else if (hr_q == 6'h11) begin
          hr_nxt = 6'h12;
          pm_nxt = !pm_q;
        end else begin
          hr_nxt = hr_inc;
        end
      end else begin
        hr_nxt = (hr_q == 6'h23) ? 6'h00 : hr_inc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      hr_q       <= HrReset;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      sec_tick_q <= adv;
      load_err_q <= load_bad || alarm_bad;
      if (load_ok)     presc_q <= '0;
      else if (enable) presc_q <= tick ? '0 : presc_q + 1'b1;
      if (load_ok) begin
        hr_q <= load_hr;
        pm_q <= Mode12 ? load_pm : 1'b0;
      end else begin
        hr_q <= hr_nxt;
        pm_q <= pm_nxt;
      end
    end
  end

  if (ALARM_EN != 0) begin : g_alarm
    logic [5:0] al_hr_q;
    logic [6:0] al_min_q;
    logic       al_pm_q, armed_q, hit_q, fire;

    assign alarm_ok  = alarm_set && alarm_valid;
    assign alarm_bad = alarm_set && !alarm_valid;
    // Only a tick-driven step onto hr:min:00 fires; loads never reach this path.
    assign fire = adv && armed_q && (sec_nxt == 7'h00) && (min_nxt == al_min_q) &&
                  (hr_nxt == al_hr_q) && (pm_nxt == al_pm_q);
    assign alarm_hit = hit_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        al_hr_q  <= HrReset;
        al_min_q <= 7'h00;
        al_pm_q  <= 1'b0;
        armed_q  <= 1'b0;
        hit_q    <= 1'b0;
      end else begin
        if (alarm_ok) begin
          al_hr_q  <= load_hr;
          al_min_q <= load_min;
          al_pm_q  <= Mode12 ? load_pm : 1'b0;
          armed_q  <= 1'b1;
        end
        if (alarm_clr)  hit_q <= 1'b0;
        else if (fire)  hit_q <= 1'b1;
      end
    end
  end else begin : g_no_alarm
    assign alarm_ok  = 1'b0;
    assign alarm_bad = 1'b0;
    assign alarm_hit = 1'b0;
  end

  assign time_hr  = hr_q;
  assign time_min = min_q;
  assign time_sec = sec_q;
  assign time_pm  = pm_q;
  assign sec_tick = sec_tick_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_digital_clock_hms.sv
// Scoreboard bench: directed loads push expected tick/error events; per-DUT monitors pop
// and compare whenever sec_tick or load_err is presented.
module tb_digital_clock_hms;

  typedef struct packed {
    logic       err;
    logic [5:0] hr;
    logic [6:0] mn;
    logic [6:0] sc;
    logic       pm;
    logic       hit;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en24 = 1'b0, en12 = 1'b0, load24 = 1'b0, load12 = 1'b0;
  logic [5:0] ld_hr = '0;
  logic [6:0] ld_min = '0, ld_sec = '0;
  logic       ld_pm = 1'b0, aset = 1'b0, aclr = 1'b0;

  logic [5:0] hr24, hr12;
  logic [6:0] min24, sec24, min12, sec12;
  logic       pm24, tick24, err24, hit24, pm12, tick12, err12, hit12;

  ev_t q24[$];
  ev_t q12[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clock = ~clock;

  digital_clock_hms #(.TICK_DIV(4), .HOUR_MODE(24), .ALARM_EN(1)) u24 (
    .clock(clock), .reset(reset), .enable(en24), .load(load24), .load_hr(ld_hr),
    .load_min(ld_min), .load_sec(ld_sec), .load_pm(ld_pm), .alarm_set(aset),
    .alarm_clr(aclr), .time_hr(hr24), .time_min(min24), .time_sec(sec24), .time_pm(pm24),
    .sec_tick(tick24), .load_err(err24), .alarm_hit(hit24)
  );

  digital_clock_hms #(.TICK_DIV(4), .HOUR_MODE(12), .ALARM_EN(1)) u12 (
    .clock(clock), .reset(reset), .enable(en12), .load(load12), .load_hr(ld_hr),
    .load_min(ld_min), .load_sec(ld_sec), .load_pm(ld_pm), .alarm_set(1'b0),
    .alarm_clr(1'b0), .time_hr(hr12), .time_min(min12), .time_sec(sec12), .time_pm(pm12),
    .sec_tick(tick12), .load_err(err12), .alarm_hit(hit12)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic err, input logic [5:0] hr, input logic [6:0] mn,
                             input logic [6:0] sc, input logic pm, input logic hit);
    return '{err: err, hr: hr, mn: mn, sc: sc, pm: pm, hit: hit};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ld24(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
    ld_hr = h; ld_min = m; ld_sec = s; ld_pm = 1'b0; load24 = 1'b1;
    step(1);
    load24 = 1'b0;
  endtask

  task automatic ld12(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s,
                      input logic p);
    ld_hr = h; ld_min = m; ld_sec = s; ld_pm = p; load12 = 1'b1;
    step(1);
    load12 = 1'b0;
  endtask

  always @(negedge clock) begin
    ev_t got;
    if (!reset && (tick24 || err24)) begin
      got = mk(err24, hr24, min24, sec24, pm24, hit24);
      if (q24.size() == 0) begin
        checks++; errors++;
        $display("FAIL ev24_unexpected: got %h expected no event", got);
      end else begin
        chk("ev24", 32'(got), 32'(q24.pop_front()));
      end
    end
  end

  always @(negedge clock) begin
    ev_t got;
    if (!reset && (tick12 || err12)) begin
      got = mk(err12, hr12, min12, sec12, pm12, hit12);
      if (q12.size() == 0) begin
        checks++; errors++;
        $display("FAIL ev12_unexpected: got %h expected no event", got);
      end else begin
        chk("ev12", 32'(got), 32'(q12.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    step(2);
    chk("rst24_hms", {hr24, min24, sec24}, '0);
    chk("rst24_flags", {pm24, tick24, err24, hit24}, '0);
    chk("rst12_hms", {hr12, min12, sec12}, {6'h12, 7'h00, 7'h00});
    chk("rst12_flags", {pm12, tick12, err12, hit12}, '0);
    reset = 1'b0;
    step(1);

    // 23:59:58 -> 23:59:59 -> 00:00:00 over 8 clocks; alarm still disarmed
    q24.push_back(mk(1'b0, 6'h23, 7'h59, 7'h59, 1'b0, 1'b0));
    q24.push_back(mk(1'b0, 6'h00, 7'h00, 7'h00, 1'b0, 1'b0));
    en24 = 1'b1;
    ld24(6'h23, 7'h59, 7'h58);
    chk("a_load_shown", {hr24, min24, sec24}, {6'h23, 7'h59, 7'h58});
    chk("a_load_no_tick", tick24, 0);
    step(8);
    en24 = 1'b0;
    step(1);
    chk("a_wrapped", {hr24, min24, sec24}, '0);

    // hour ones carry 09 -> 10
    q24.push_back(mk(1'b0, 6'h10, 7'h00, 7'h00, 1'b0, 1'b0));
    en24 = 1'b1;
    ld24(6'h09, 7'h59, 7'h59);
    step(4);
    en24 = 1'b0;
    step(1);

    // rejected loads leave 10:00:00 in place
    q24.push_back(mk(1'b1, 6'h10, 7'h00, 7'h00, 1'b0, 1'b0));
    ld24(6'h24, 7'h00, 7'h00);
    step(1);
    q24.push_back(mk(1'b1, 6'h10, 7'h00, 7'h00, 1'b0, 1'b0));
    ld24(6'h05, 7'h6A, 7'h00);
    step(1);
    chk("bad_time_kept", {hr24, min24, sec24}, {6'h10, 7'h00, 7'h00});

    // asynchronous reset in the middle of a count
    en24 = 1'b1;
    ld24(6'h07, 7'h42, 7'h13);
    step(2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_hms", {hr24, min24, sec24}, '0);
    chk("mid_rst_flags", {tick24, hit24}, '0);
    en24 = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    step(1);

    // alarm 06:30: fires on tick, sticky, cleared, not fired by load
    ld_hr = 6'h06; ld_min = 7'h30; ld_sec = 7'h00; ld_pm = 1'b0; aset = 1'b1;
    step(1);
    aset = 1'b0;
    q24.push_back(mk(1'b0, 6'h06, 7'h30, 7'h00, 1'b0, 1'b1));
    en24 = 1'b1;
    ld24(6'h06, 7'h29, 7'h59);
    step(4);
    en24 = 1'b0;
    step(3);
    chk("alarm_held", hit24, 1);
    aclr = 1'b1;
    step(1);
    aclr = 1'b0;
    chk("alarm_cleared", hit24, 0);
    en24 = 1'b1;
    ld24(6'h06, 7'h30, 7'h00);
    step(3);
    en24 = 1'b0;
    chk("alarm_load_nohit", hit24, 0);
    chk("alarm_load_time", {hr24, min24, sec24}, {6'h06, 7'h30, 7'h00});

    // load on the terminal-count edge drops that tick; next tick 4 clocks later
    q24.push_back(mk(1'b0, 6'h10, 7'h20, 7'h31, 1'b0, 1'b0));
    en24 = 1'b1;
    ld24(6'h10, 7'h00, 7'h00);
    step(3);
    ld24(6'h10, 7'h20, 7'h30);
    chk("coinc_shown", {hr24, min24, sec24}, {6'h10, 7'h20, 7'h30});
    chk("coinc_no_tick", tick24, 0);
    step(4);
    en24 = 1'b0;
    step(1);

    // 12-hour mode boundaries
    q12.push_back(mk(1'b0, 6'h12, 7'h00, 7'h00, 1'b1, 1'b0));
    en12 = 1'b1;
    ld12(6'h11, 7'h59, 7'h59, 1'b0);
    step(4);
    en12 = 1'b0;
    step(1);
    q12.push_back(mk(1'b0, 6'h01, 7'h00, 7'h00, 1'b1, 1'b0));
    en12 = 1'b1;
    ld12(6'h12, 7'h59, 7'h59, 1'b1);
    step(4);
    en12 = 1'b0;
    step(1);
    q12.push_back(mk(1'b1, 6'h01, 7'h00, 7'h00, 1'b1, 1'b0));
    ld12(6'h00, 7'h30, 7'h00, 1'b0);
    step(1);
    q12.push_back(mk(1'b0, 6'h12, 7'h00, 7'h00, 1'b0, 1'b0));
    en12 = 1'b1;
    ld12(6'h11, 7'h59, 7'h59, 1'b1);
    step(4);
    en12 = 1'b0;
    step(2);

    chk("q24_drained", q24.size(), 0);
    chk("q12_drained", q12.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
